// File: rtl/coin_acceptor.sv
// Coin sensor front end: 2-flop sync, debounce and one-hot classify of three coin lines.
// Latency: coin_valid rises DEBOUNCE_CYCLES+1 edges after the raw line is first sampled; no backpressure.
// Optional COIN_COUNT_EN adds saturating accept/reject counters.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sense_ten,
    input  logic       sense_twenty,
    input  logic       sense_fifty,
    output logic [1:0] coin,
    output logic       coin_valid,
    output logic       reject,
`ifdef COIN_COUNT_EN
    output logic [7:0] accept_count,
    output logic [7:0] reject_count,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        RELEASE,
        REJECT
    } state_t;

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       pat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    state_t           state_q;
    logic [1:0]       coin_q;
    logic             coin_valid_q;
    logic             reject_q;
    logic             busy_q;
    logic             single;
    logic             multi;

    function automatic logic [1:0] code_of(input logic [2:0] p);
        if (p[2])      return 2'b10;
        else if (p[1]) return 2'b01;
        else           return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {sense_fifty, sense_twenty, sense_ten};
            sync2_q <= sync1_q;
        end
    end

    // s & (s-1) clears the lowest set bit, so zero means at most one bit set.
    assign single = (sync2_q != 3'b000) && ((sync2_q & (sync2_q - 3'b001)) == 3'b000);
    assign multi  = (sync2_q != 3'b000) && !single;
    assign cnt_d  = cnt_q + 1'b1;

    // Strobes are raised on the transition into EMIT/REJECT so they are high exactly while in that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pat_q        <= 3'b000;
            cnt_q        <= '0;
            coin_q       <= 2'b00;
            coin_valid_q <= 1'b0;
            reject_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            coin_valid_q <= 1'b0;
            reject_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (single) begin
                        pat_q   <= sync2_q;
                        cnt_q   <= CNT_W'(1);
                        state_q <= DEBOUNCE;
                        busy_q  <= 1'b1;
                    end else if (multi) begin
                        state_q  <= REJECT;
                        reject_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (sync2_q == pat_q) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == DB_LIMIT) begin
                            state_q      <= EMIT;
                            coin_q       <= code_of(pat_q);
                            coin_valid_q <= 1'b1;
                        end
                    end else if (multi) begin
                        state_q  <= REJECT;
                        reject_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                EMIT, REJECT: begin
                    state_q <= RELEASE;
                    cnt_q   <= '0;
                end
                RELEASE: begin
                    if (sync2_q == 3'b000) begin
                        if (cnt_d == DB_LIMIT) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coin       = coin_q;
    assign coin_valid = coin_valid_q;
    assign reject     = reject_q;
    assign busy       = busy_q;

`ifdef COIN_COUNT_EN
    logic [7:0] acc_cnt_q;
    logic [7:0] rej_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_cnt_q <= 8'd0;
            rej_cnt_q <= 8'd0;
        end else begin
            if (coin_valid_q && (acc_cnt_q != 8'hFF)) acc_cnt_q <= acc_cnt_q + 8'd1;
            if (reject_q && (rej_cnt_q != 8'hFF))     rej_cnt_q <= rej_cnt_q + 8'd1;
        end
    end

    assign accept_count = acc_cnt_q;
    assign reject_count = rej_cnt_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: latency, glitch rejection, multi-hit, hold, mid-op reset.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sense_ten = 1'b0;
    logic       sense_twenty = 1'b0;
    logic       sense_fifty = 1'b0;
    logic [1:0] coin;
    logic       coin_valid;
    logic       reject;
    logic       busy;
`ifdef COIN_COUNT_EN
    logic [7:0] accept_count;
    logic [7:0] reject_count;
`endif

    int checks = 0;
    int errors = 0;
    int nv = 0;
    int nr = 0;
    int nboth = 0;
    int base_v;
    int base_r;

    coin_acceptor dut (
        .clk          (clk),
        .reset        (rst_n),
        .sense_ten    (sense_ten),
        .sense_twenty (sense_twenty),
        .sense_fifty  (sense_fifty),
        .coin         (coin),
        .coin_valid   (coin_valid),
        .reject       (reject),
`ifdef COIN_COUNT_EN
        .accept_count (accept_count),
        .reject_count (reject_count),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (coin_valid)           nv++;
            if (reject)               nr++;
            if (coin_valid && reject) nboth++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        base_v = nv;
        base_r = nr;
    endtask

    initial begin
        cyc(2);
        check("rst_coin", 32'(coin), 0);
        check("rst_valid", 32'(coin_valid), 0);
        check("rst_reject", 32'(reject), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        cyc(3);

        // 1: twenty held 10 cycles, strobe on 5th edge after first sample
        snap();
        sense_twenty = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5) check("t1_valid_e5", 32'(coin_valid), 0);
            if (i == 6) begin
                check("t1_valid_e6", 32'(coin_valid), 1);
                check("t1_coin", 32'(coin), 1);
            end
            if (i == 7) check("t1_valid_e7", 32'(coin_valid), 0);
        end
        sense_twenty = 1'b0;
        cyc(5);
        check("t1_busy_hold", 32'(busy), 1);
        cyc(1);
        check("t1_busy_idle", 32'(busy), 0);
        check("t1_nvalid", 32'(nv - base_v), 1);
        check("t1_nreject", 32'(nr - base_r), 0);

        // 2: 2-cycle glitch on ten
        snap();
        sense_ten = 1'b1;
        cyc(2);
        sense_ten = 1'b0;
        cyc(10);
        check("t2_nvalid", 32'(nv - base_v), 0);
        check("t2_nreject", 32'(nr - base_r), 0);
        check("t2_busy", 32'(busy), 0);
        check("t2_coin", 32'(coin), 1);

        // 3: ten+fifty together, early re-insert blocked, later one accepted
        snap();
        sense_ten = 1'b1;
        sense_fifty = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 3) check("t3_reject_e3", 32'(reject), 1);
            if (i == 4) check("t3_reject_e4", 32'(reject), 0);
        end
        sense_ten = 1'b0;
        sense_fifty = 1'b0;
        cyc(2);
        sense_ten = 1'b1;
        cyc(6);
        sense_ten = 1'b0;
        check("t3_early_nvalid", 32'(nv - base_v), 0);
        check("t3_nreject", 32'(nr - base_r), 1);
        check("t3_coin_kept", 32'(coin), 1);
        cyc(8);
        check("t3_busy_idle", 32'(busy), 0);
        sense_ten = 1'b1;
        cyc(6);
        sense_ten = 1'b0;
        cyc(8);
        check("t3_late_nvalid", 32'(nv - base_v), 1);
        check("t3_late_coin", 32'(coin), 0);

        // 4: fifty held 50 cycles
        snap();
        sense_fifty = 1'b1;
        cyc(3);
        for (int i = 3; i <= 50; i++) begin
            if (i == 3 || i == 25 || i == 50) check("t4_busy", 32'(busy), 1);
            if (i < 50) cyc(1);
        end
        sense_fifty = 1'b0;
        check("t4_nvalid", 32'(nv - base_v), 1);
        check("t4_coin", 32'(coin), 2);
        cyc(10);
        check("t4_busy_idle", 32'(busy), 0);

        // 5: reset mid-debounce
        sense_twenty = 1'b1;
        cyc(4);
        rst_n = 1'b0;
        sense_twenty = 1'b0;
        #1;
        check("t5_rst_coin", 32'(coin), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_valid", 32'(coin_valid), 0);
        check("t5_rst_reject", 32'(reject), 0);
`ifdef COIN_COUNT_EN
        check("t5_rst_acc", 32'(accept_count), 0);
        check("t5_rst_rej", 32'(reject_count), 0);
`endif
        cyc(2);
        rst_n = 1'b1;
        snap();
        cyc(12);
        check("t5_no_strobe", 32'(nv - base_v), 0);
        check("t5_busy", 32'(busy), 0);
        sense_ten = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 6) begin
                check("t5_valid", 32'(coin_valid), 1);
                check("t5_coin", 32'(coin), 0);
            end
        end
        sense_ten = 1'b0;
        cyc(8);

`ifdef COIN_COUNT_EN
        // 6: saturating counters
        for (int k = 0; k < 300; k++) begin
            sense_twenty = 1'b1;
            cyc(5);
            sense_twenty = 1'b0;
            cyc(7);
        end
        for (int k = 0; k < 3; k++) begin
            sense_ten = 1'b1;
            sense_twenty = 1'b1;
            cyc(3);
            sense_ten = 1'b0;
            sense_twenty = 1'b0;
            cyc(7);
        end
        check("t6_accept_count", 32'(accept_count), 255);
        check("t6_reject_count", 32'(reject_count), 3);
`endif

        check("excl_both", 32'(nboth), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage that feeds the vending FSM's 2-bit coin input. Three raw coin-sensor lines (10, 20, 50) are synchronised, debounced and classified. A one-hot-valid coin produces a registered coin code plus a single-cycle coin_valid strobe. The downstream vend FSM advances only on cycles where coin_valid is high. Simultaneous multi-sensor hits are flagged as rejects.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a coin, and consecutive all-low samples needed to re-arm; legal range 2..15.
CNT_W, 4, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
sense_ten  input  1  raw 10-unit coin sensor, asynchronous to clk.
sense_twenty  input  1  raw 20-unit coin sensor, asynchronous to clk.
sense_fifty  input  1  raw 50-unit coin sensor, asynchronous to clk.
coin  output  2  accepted coin code: 00 = ten, 01 = twenty, 10 = fifty; holds the last accepted value.
coin_valid  output  1  one-cycle strobe: coin is a new accepted coin.
reject  output  1  one-cycle strobe: more than one sensor was active simultaneously.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, named reset.
- Reset values: coin = 00, coin_valid = 0, reject = 0, busy = 0, state = IDLE, counter = 0, synchroniser flops = 0.
- Synchronisation: each sense line passes through a 2-flop synchroniser. The FSM sees only the second flop, called vector s[2:0] = {fifty, twenty, ten}.
- Classification:
  - single = exactly one bit of s high.
  - multi = two or more bits of s high.
  - Code mapping: ten → 00, twenty → 01, fifty → 10. Code 11 is never emitted.
- FSM states: IDLE, DEBOUNCE, EMIT, RELEASE, REJECT.
  - IDLE:
    - single: latch the one-hot pattern, cnt = 1, go to DEBOUNCE.
    - multi: go to REJECT.
    - otherwise: stay in IDLE.
  - DEBOUNCE:
    - s equals the latched pattern: cnt++. When cnt reaches DEBOUNCE_CYCLES, go to EMIT.
    - multi: go to REJECT.
    - s is 0 or a different single pattern: glitch; go to IDLE with no output.
  - EMIT (one cycle): register coin = code, register coin_valid = 1 for exactly one cycle, then go to RELEASE with cnt = 0.
  - REJECT (one cycle): reject = 1 for exactly one cycle; coin is unchanged; then go to RELEASE with cnt = 0.
  - RELEASE:
    - s == 0: cnt++.
    - any bit of s high: cnt = 0.
    - cnt reaches DEBOUNCE_CYCLES: go to IDLE.
- Latency: with a clean input, coin_valid rises on the (DEBOUNCE_CYCLES+1)th rising edge after the edge that first samples the raw line high. With the default, that is edge 5.
- Held sensor: a line stuck high yields exactly one coin_valid; the block stays in RELEASE indefinitely. No auto-repeat.
- Exclusivity: coin_valid and reject are never high in the same cycle. At most one strobe per coin insertion.
- Reset mid-operation: all state, counter and outputs clear immediately. No pending strobe is emitted after reset is released. A coin must be fully re-debounced from IDLE.
- Output timing: all outputs are registered, with no combinational path from sense inputs to outputs.

Optional Feature:
Macro COIN_COUNT_EN.
- Defined:
  - Adds output accept_count[7:0]: increments on every coin_valid, saturates at 255.
  - Adds output reject_count[7:0]: increments on every reject, saturates at 255.
  - Both counters are cleared by reset.
- Not defined: neither counter nor either port exists; all other behaviour is identical.

Test Plan:
1. Default params; sense_twenty held high 10 cycles, then low → exactly one coin_valid on the 5th edge after the first sampling edge; coin = 01; reject stays 0; busy returns to 0 four cycles after the line drops (plus sync delay).
2. sense_ten pulsed high for 2 cycles → no coin_valid, no reject; FSM back in IDLE; coin keeps its previous value.
3. sense_ten and sense_fifty raised in the same cycle for 6 cycles → single reject pulse, no coin_valid. A sense_ten coin applied 2 cycles after release is not accepted; one applied after ≥4 low cycles is accepted (coin = 00).
4. sense_fifty held high 50 cycles → exactly one coin_valid, coin = 10; busy high throughout the hold.
5. sense_twenty high, reset driven to 0 on the 3rd debounce cycle, released 2 cycles later with the sensor low → all outputs 0 and no strobe afterwards. The next clean sense_ten coin yields coin = 00 with coin_valid.
6. COIN_COUNT_EN defined; 300 clean coins plus 3 multi-sensor hits → accept_count = 255 (saturated), reject_count = 3.
